// File: rtl/memory_access.sv
// Memory-access pipeline stage: registers the execute-stage op, issues at most one
// data-memory request per captured load/store, holds the pipe until dmem_ack, and
// formats load data / store lanes. Only DATA_WIDTH = 32 is supported.
module memory_access #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  // execute side
  input  logic                     valid_e,
  input  logic                     flush_e,
  input  logic                     reg_write_e,
  input  logic                     mem_write_e,
  input  logic [1:0]               result_src_e,
  input  logic [2:0]               funct3_e,
  input  logic [DATA_WIDTH-1:0]    alu_result_e,
  input  logic [DATA_WIDTH-1:0]    write_data_e,
  input  logic [4:0]               rd_e,
  input  logic [ADDRESS_WIDTH-1:0] pc_plus4_e,
  // data memory
  output logic                     dmem_req,
  output logic                     dmem_we,
  output logic [ADDRESS_WIDTH-1:0] dmem_addr,
  output logic [31:0]              dmem_wdata,
  output logic [3:0]               dmem_be,
  input  logic                     dmem_ack,
  input  logic [31:0]              dmem_rdata,
  // writeback side
  output logic                     reg_write_m,
  output logic [1:0]               result_src_m,
  output logic [DATA_WIDTH-1:0]    alu_result_m,
  output logic [DATA_WIDTH-1:0]    read_data_m,
  output logic [4:0]               rd_m,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4_m,
  // status
  output logic                     stall_m,
  output logic                     misaligned_m
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  localparam logic [1:0] SrcLoad = 2'b01;

  state_e                   state_q;
  logic                     valid_q;
  logic                     reg_write_q;
  logic                     mem_write_q;
  logic [1:0]               result_src_q;
  logic [2:0]               funct3_q;
  logic [DATA_WIDTH-1:0]    alu_result_q;
  logic [DATA_WIDTH-1:0]    write_data_q;
  logic [4:0]               rd_q;
  logic [ADDRESS_WIDTH-1:0] pc_plus4_q;

  // Halfword accesses need addr[0]=0 (lh/lhu/sh), words need addr[1:0]=0 (lw/sw).
  function automatic logic misalign_f(input logic [2:0] f3, input logic [1:0] a);
    logic bad;
    bad = 1'b0;
    if (f3[1:0] == 2'b01) begin
      bad = a[0];
    end else if (f3 == 3'b010) begin
      bad = |a;
    end
    return bad;
  endfunction

  logic       busy;
  logic       valid_in;
  logic       mem_op_in;
  logic       mem_kind_q;
  logic       misaligned;
  logic       is_load_q;
  logic [1:0] lsb;

  assign busy      = (state_q == StBusy);
  assign lsb       = alu_result_q[1:0];
  assign valid_in  = valid_e & ~flush_e;
  // A captured op only becomes a memory request if it is valid and aligned.
  assign mem_op_in = valid_in & ((result_src_e == SrcLoad) | mem_write_e)
                     & ~misalign_f(funct3_e, alu_result_e[1:0]);

  assign mem_kind_q = (result_src_q == SrcLoad) | mem_write_q;
  assign is_load_q  = (result_src_q == SrcLoad) & ~mem_write_q;
  assign misaligned = valid_q & mem_kind_q & misalign_f(funct3_q, lsb);

  // M register and FSM; everything holds while the memory access is outstanding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      result_src_q <= 2'b00;
      funct3_q     <= 3'b000;
      alu_result_q <= '0;
      write_data_q <= '0;
      rd_q         <= 5'd0;
      pc_plus4_q   <= '0;
    end else if (!stall_m) begin
      state_q      <= mem_op_in ? StBusy : StIdle;
      valid_q      <= valid_in;
      reg_write_q  <= reg_write_e;
      mem_write_q  <= mem_write_e;
      result_src_q <= result_src_e;
      funct3_q     <= funct3_e;
      alu_result_q <= alu_result_e;
      write_data_q <= write_data_e;
      rd_q         <= rd_e;
      pc_plus4_q   <= pc_plus4_e;
    end
  end

  // Request side: ack is only meaningful while a request is outstanding.
  always_comb begin
    stall_m      = busy & ~dmem_ack;
    dmem_req     = busy;
    dmem_we      = busy & mem_write_q;
    dmem_addr    = {alu_result_q[ADDRESS_WIDTH-1:2], 2'b00};
    misaligned_m = misaligned;
  end

  // Store lane selection: narrow data is replicated so any enabled lane sees it.
  always_comb begin
    dmem_be    = 4'b1111;
    dmem_wdata = write_data_q[31:0];
    case (funct3_q[1:0])
      2'b00: begin
        dmem_be    = 4'b0001 << lsb;
        dmem_wdata = {4{write_data_q[7:0]}};
      end
      2'b01: begin
        dmem_be    = lsb[1] ? 4'b1100 : 4'b0011;
        dmem_wdata = {2{write_data_q[15:0]}};
      end
      default: begin
        dmem_be    = 4'b1111;
        dmem_wdata = write_data_q[31:0];
      end
    endcase
  end

  // Load formatting; data is only presented in the cycle the load is acknowledged.
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_fmt;

  always_comb begin
    case (lsb)
      2'b00:   byte_sel = dmem_rdata[7:0];
      2'b01:   byte_sel = dmem_rdata[15:8];
      2'b10:   byte_sel = dmem_rdata[23:16];
      default: byte_sel = dmem_rdata[31:24];
    endcase
    half_sel = lsb[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (funct3_q)
      3'b000:  load_fmt = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_fmt = {24'h0, byte_sel};
      3'b001:  load_fmt = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_fmt = {16'h0, half_sel};
      default: load_fmt = dmem_rdata;
    endcase
  end

  // Writeback side: stores never write a register; loads only in their ack cycle.
  always_comb begin
    read_data_m  = (busy & dmem_ack & is_load_q) ? load_fmt : '0;
    reg_write_m  = valid_q & reg_write_q & ~misaligned & ~stall_m & ~mem_write_q;
    result_src_m = result_src_q;
    alu_result_m = alu_result_q;
    rd_m         = rd_q;
    pc_plus4_m   = pc_plus4_q;
  end

endmodule

// File: tb/tb_memory_access.sv
module tb_memory_access;

  logic        clk;
  logic        rst;
  logic        valid_e, flush_e, reg_write_e, mem_write_e;
  logic [1:0]  result_src_e;
  logic [2:0]  funct3_e;
  logic [31:0] alu_result_e, write_data_e;
  logic [4:0]  rd_e;
  logic [31:0] pc_plus4_e;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        reg_write_m;
  logic [1:0]  result_src_m;
  logic [31:0] alu_result_m, read_data_m;
  logic [4:0]  rd_m;
  logic [31:0] pc_plus4_m;
  logic        stall_m, misaligned_m;

  int unsigned vectors;
  int unsigned miscompares;

  memory_access #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .valid_e(valid_e), .flush_e(flush_e), .reg_write_e(reg_write_e),
    .mem_write_e(mem_write_e), .result_src_e(result_src_e), .funct3_e(funct3_e),
    .alu_result_e(alu_result_e), .write_data_e(write_data_e), .rd_e(rd_e),
    .pc_plus4_e(pc_plus4_e),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata),
    .reg_write_m(reg_write_m), .result_src_m(result_src_m), .alu_result_m(alu_result_m),
    .read_data_m(read_data_m), .rd_m(rd_m), .pc_plus4_m(pc_plus4_m),
    .stall_m(stall_m), .misaligned_m(misaligned_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_e();
    valid_e = 0; flush_e = 0; reg_write_e = 0; mem_write_e = 0;
    result_src_e = 2'b00; funct3_e = 3'b000; alu_result_e = 0; write_data_e = 0;
    rd_e = 0; pc_plus4_e = 0;
  endtask

  task automatic drive_op(input logic v, input logic fl, input logic rw, input logic mw,
                          input logic [1:0] rs, input logic [2:0] f3, input logic [31:0] alu,
                          input logic [31:0] wd, input logic [4:0] rd, input logic [31:0] pc);
    valid_e = v; flush_e = fl; reg_write_e = rw; mem_write_e = mw; result_src_e = rs;
    funct3_e = f3; alu_result_e = alu; write_data_e = wd; rd_e = rd; pc_plus4_e = pc;
  endtask

  task automatic test_reset();
    rst = 1'b1; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    clear_e();
    drive_op(1, 0, 1, 0, 2'b10, 3'b111, 32'hDEAD_BEEF, 32'h1, 5'd7, 32'h44);
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    vectors++; if (dmem_req !== 1'b0) begin miscompares++;
      $display("FAIL reset_req got %0b want 0", dmem_req); end
    vectors++; if (stall_m !== 1'b0) begin miscompares++;
      $display("FAIL reset_stall got %0b want 0", stall_m); end
    vectors++; if (reg_write_m !== 1'b0) begin miscompares++;
      $display("FAIL reset_regwrite got %0b want 0", reg_write_m); end
    vectors++; if (misaligned_m !== 1'b0) begin miscompares++;
      $display("FAIL reset_misaligned got %0b want 0", misaligned_m); end
    vectors++; if ({alu_result_m, rd_m, pc_plus4_m, result_src_m} !== '0) begin miscompares++;
      $display("FAIL reset_mreg got alu=%h rd=%0d pc=%h src=%0d want all 0",
               alu_result_m, rd_m, pc_plus4_m, result_src_m); end
    clear_e();
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_alu();
    drive_op(1, 0, 1, 0, 2'b00, 3'b000, 32'h1234, 32'h0, 5'd5, 32'h104);
    @(posedge clk); #1; clear_e();
    @(negedge clk);
    vectors++; if (reg_write_m !== 1'b1) begin miscompares++;
      $display("FAIL alu_regwrite got %0b want 1", reg_write_m); end
    vectors++; if (rd_m !== 5'd5) begin miscompares++;
      $display("FAIL alu_rd got %0d want 5", rd_m); end
    vectors++; if (alu_result_m !== 32'h1234) begin miscompares++;
      $display("FAIL alu_result got %h want 00001234", alu_result_m); end
    vectors++; if (stall_m !== 1'b0 || dmem_req !== 1'b0) begin miscompares++;
      $display("FAIL alu_nostall got stall=%0b req=%0b want 0 0", stall_m, dmem_req); end
    @(posedge clk); #1;
    @(negedge clk);
    vectors++; if (reg_write_m !== 1'b0) begin miscompares++;
      $display("FAIL alu_single_pulse got %0b want 0", reg_write_m); end
    @(posedge clk); #1;
  endtask

  task automatic test_lb_wait();
    drive_op(1, 0, 1, 0, 2'b01, 3'b000, 32'h103, 32'h0, 5'd9, 32'h200);
    @(posedge clk); #1; clear_e();
    dmem_ack = 1'b0; dmem_rdata = 32'h80_12_34_56;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++; if (stall_m !== 1'b1 || dmem_req !== 1'b1) begin miscompares++;
        $display("FAIL lb_wait%0d got stall=%0b req=%0b want 1 1", i, stall_m, dmem_req); end
      vectors++; if (dmem_addr !== 32'h100) begin miscompares++;
        $display("FAIL lb_addr%0d got %h want 00000100", i, dmem_addr); end
      vectors++; if (reg_write_m !== 1'b0 || read_data_m !== 32'h0) begin miscompares++;
        $display("FAIL lb_early%0d got rw=%0b rd=%h want 0 0", i, reg_write_m, read_data_m); end
      @(posedge clk); #1;
    end
    dmem_ack = 1'b1;
    @(negedge clk);
    vectors++; if (read_data_m !== 32'hFFFF_FF80) begin miscompares++;
      $display("FAIL lb_data got %h want ffffff80", read_data_m); end
    vectors++; if (reg_write_m !== 1'b1 || stall_m !== 1'b0) begin miscompares++;
      $display("FAIL lb_done got rw=%0b stall=%0b want 1 0", reg_write_m, stall_m); end
    @(posedge clk); #1; dmem_ack = 1'b0;
    @(negedge clk);
    vectors++; if (dmem_req !== 1'b0) begin miscompares++;
      $display("FAIL lb_release got req=%0b want 0", dmem_req); end
    @(posedge clk); #1;
  endtask

  task automatic test_sh();
    drive_op(1, 0, 1, 1, 2'b00, 3'b001, 32'h22, 32'h0000_ABCD, 5'd3, 32'h300);
    @(posedge clk); #1; clear_e(); dmem_ack = 1'b0;
    @(negedge clk);
    vectors++; if (dmem_be !== 4'b1100) begin miscompares++;
      $display("FAIL sh_be got %b want 1100", dmem_be); end
    vectors++; if (dmem_wdata !== 32'hABCD_ABCD) begin miscompares++;
      $display("FAIL sh_wdata got %h want abcdabcd", dmem_wdata); end
    vectors++; if (dmem_we !== 1'b1 || dmem_req !== 1'b1) begin miscompares++;
      $display("FAIL sh_we got we=%0b req=%0b want 1 1", dmem_we, dmem_req); end
    @(posedge clk); #1; dmem_ack = 1'b1;
    @(negedge clk);
    vectors++; if (reg_write_m !== 1'b0 || stall_m !== 1'b0) begin miscompares++;
      $display("FAIL sh_ack got rw=%0b stall=%0b want 0 0", reg_write_m, stall_m); end
    @(posedge clk); #1; dmem_ack = 1'b0;
  endtask

  task automatic test_misaligned();
    drive_op(1, 0, 1, 0, 2'b01, 3'b010, 32'h41, 32'h0, 5'd4, 32'h400);
    @(posedge clk); #1; clear_e();
    @(negedge clk);
    vectors++; if (misaligned_m !== 1'b1) begin miscompares++;
      $display("FAIL mis_flag got %0b want 1", misaligned_m); end
    vectors++; if (dmem_req !== 1'b0 || stall_m !== 1'b0) begin miscompares++;
      $display("FAIL mis_noreq got req=%0b stall=%0b want 0 0", dmem_req, stall_m); end
    vectors++; if (reg_write_m !== 1'b0) begin miscompares++;
      $display("FAIL mis_regwrite got %0b want 0", reg_write_m); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int stalls;
    int pulses;
    stalls = 0; pulses = 0;
    drive_op(1, 0, 1, 0, 2'b01, 3'b010, 32'h200, 32'h0, 5'd10, 32'h500);
    @(posedge clk); #1;
    drive_op(1, 0, 1, 0, 2'b01, 3'b010, 32'h204, 32'h0, 5'd11, 32'h504);
    dmem_ack = 1'b1; dmem_rdata = 32'h1111_2222;
    @(negedge clk);
    if (stall_m) stalls++;
    if (reg_write_m) pulses++;
    vectors++; if (rd_m !== 5'd10 || read_data_m !== 32'h1111_2222) begin miscompares++;
      $display("FAIL b2b_first got rd=%0d data=%h want 10 11112222", rd_m, read_data_m); end
    @(posedge clk); #1; clear_e(); dmem_rdata = 32'h3333_4444;
    @(negedge clk);
    if (stall_m) stalls++;
    if (reg_write_m) pulses++;
    vectors++; if (rd_m !== 5'd11 || read_data_m !== 32'h3333_4444) begin miscompares++;
      $display("FAIL b2b_second got rd=%0d data=%h want 11 33334444", rd_m, read_data_m); end
    vectors++; if (dmem_addr !== 32'h204 || dmem_req !== 1'b1) begin miscompares++;
      $display("FAIL b2b_req2 got addr=%h req=%0b want 00000204 1", dmem_addr, dmem_req); end
    @(posedge clk); #1; dmem_ack = 1'b0;
    @(negedge clk);
    vectors++; if (stalls != 0 || pulses != 2) begin miscompares++;
      $display("FAIL b2b_counts got stalls=%0d pulses=%0d want 0 2", stalls, pulses); end
    vectors++; if (dmem_req !== 1'b0 || reg_write_m !== 1'b0) begin miscompares++;
      $display("FAIL b2b_idle got req=%0b rw=%0b want 0 0", dmem_req, reg_write_m); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_busy();
    drive_op(1, 0, 1, 0, 2'b01, 3'b010, 32'h300, 32'h0, 5'd12, 32'h600);
    @(posedge clk); #1; clear_e(); dmem_ack = 1'b0;
    @(negedge clk);
    vectors++; if (dmem_req !== 1'b1) begin miscompares++;
      $display("FAIL rstbusy_pre got req=%0b want 1", dmem_req); end
    @(posedge clk); #2; rst = 1'b1; #1;
    vectors++; if (dmem_req !== 1'b0 || stall_m !== 1'b0) begin miscompares++;
      $display("FAIL rstbusy_async got req=%0b stall=%0b want 0 0", dmem_req, stall_m); end
    @(negedge clk); rst = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_F00D;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++; if (reg_write_m !== 1'b0 || dmem_req !== 1'b0 || read_data_m !== 32'h0)
      begin miscompares++;
        $display("FAIL rstbusy_ack%0d got rw=%0b req=%0b data=%h want 0 0 0",
                 i, reg_write_m, dmem_req, read_data_m); end
      @(negedge clk);
    end
    dmem_ack = 1'b0;
    @(posedge clk); #1;
  endtask

  // Random ops checked against a transaction-level model of the stage.
  task automatic test_random();
    logic [2:0]  ld_tab [5];
    logic [2:0]  f3;
    logic [31:0] addr, wd, pc, rdata, sh, tmp, exp_wd, exp_rd;
    logic [3:0]  exp_be;
    logic [4:0]  rd;
    logic [1:0]  rs;
    logic        v, fl, rw, mw, captured, mis, mem, exp_rw, spur;
    int          kind, size, off, lat;
    ld_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 3);
      v = ($urandom_range(0, 9) != 0);
      fl = ($urandom_range(0, 9) == 0);
      rw = 1'($urandom_range(0, 1));
      mw = (kind == 2);
      rs = (kind == 1) ? 2'b01 : (kind == 3) ? 2'b10 : 2'b00;
      if (kind == 1) f3 = ld_tab[$urandom_range(0, 4)];
      else if (kind == 2) f3 = 3'($urandom_range(0, 2));
      else f3 = 3'($urandom_range(0, 7));
      addr = $urandom; wd = $urandom; pc = $urandom; rdata = $urandom;
      rd = 5'($urandom_range(0, 31));
      lat = $urandom_range(0, 3);
      // model
      size = 1 << int'(f3[1:0]);
      off = int'(addr[1:0]);
      captured = v && !fl;
      mis = captured && (kind == 1 || kind == 2) && ((off % size) != 0);
      mem = captured && (kind == 1 || kind == 2) && !mis;
      for (int b = 0; b < 4; b++) begin
        exp_be[b] = (b >= off) && (b < off + size);
        tmp = wd >> (8 * (b % size));
        exp_wd[8*b +: 8] = tmp[7:0];
      end
      sh = rdata >> (8 * off);
      if (size == 1) begin
        exp_rd = {24'h0, sh[7:0]};
        if (!f3[2] && sh[7]) exp_rd = exp_rd | 32'hFFFF_FF00;
      end else if (size == 2) begin
        exp_rd = {16'h0, sh[15:0]};
        if (!f3[2] && sh[15]) exp_rd = exp_rd | 32'hFFFF_0000;
      end else begin
        exp_rd = rdata;
      end
      drive_op(v, fl, rw, mw, rs, f3, addr, wd, rd, pc);
      @(posedge clk); #1; clear_e(); dmem_rdata = rdata;
      if (mem) begin
        for (int k = 0; k <= lat; k++) begin
          dmem_ack = (k == lat);
          exp_rw = (k == lat) && (kind == 1) && rw;
          @(negedge clk);
          vectors++; if (dmem_req !== 1'b1 || stall_m !== (k != lat)) begin miscompares++;
            $display("FAIL rnd%0d_req got req=%0b stall=%0b want 1 %0b",
                     n, dmem_req, stall_m, k != lat); end
          vectors++; if (dmem_addr !== {addr[31:2], 2'b00} || dmem_we !== mw) begin
            miscompares++;
            $display("FAIL rnd%0d_addr got addr=%h we=%0b want %h %0b",
                     n, dmem_addr, dmem_we, {addr[31:2], 2'b00}, mw); end
          if (kind == 2) begin
            vectors++; if (dmem_be !== exp_be || dmem_wdata !== exp_wd) begin miscompares++;
              $display("FAIL rnd%0d_store got be=%b wd=%h want %b %h",
                       n, dmem_be, dmem_wdata, exp_be, exp_wd); end
          end
          vectors++; if (reg_write_m !== exp_rw) begin miscompares++;
            $display("FAIL rnd%0d_rw got %0b want %0b", n, reg_write_m, exp_rw); end
          vectors++; if (read_data_m !== ((k == lat && kind == 1) ? exp_rd : 32'h0)) begin
            miscompares++;
            $display("FAIL rnd%0d_load got %h want %h", n, read_data_m,
                     (k == lat && kind == 1) ? exp_rd : 32'h0); end
          @(posedge clk); #1;
        end
        dmem_ack = 1'b0;
      end else begin
        spur = 1'($urandom_range(0, 1));
        dmem_ack = spur;
        exp_rw = captured && rw && !mis && (kind != 2);
        @(negedge clk);
        vectors++; if (dmem_req !== 1'b0 || stall_m !== 1'b0) begin miscompares++;
          $display("FAIL rnd%0d_idle got req=%0b stall=%0b want 0 0", n, dmem_req, stall_m);
        end
        vectors++; if (misaligned_m !== mis || reg_write_m !== exp_rw) begin miscompares++;
          $display("FAIL rnd%0d_flags got mis=%0b rw=%0b want %0b %0b",
                   n, misaligned_m, reg_write_m, mis, exp_rw); end
        vectors++; if (read_data_m !== 32'h0) begin miscompares++;
          $display("FAIL rnd%0d_nodata got %h want 0", n, read_data_m); end
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        // settle the bubble captured at the last edge before the next op
      end
      vectors++; if (rd_m !== 5'd0 && reg_write_m === 1'b1) begin miscompares++;
        $display("FAIL rnd%0d_bubble got rw=%0b want 0", n, reg_write_m); end
      if (!mem) begin
        // pass-through fields of the op just retired are checked on the next op's entry
      end
      drive_op(v, fl, rw, mw, rs, f3, addr, wd, rd, pc);
      @(posedge clk); #1; clear_e();
      if (!mem) begin
        @(negedge clk);
        vectors++; if (alu_result_m !== addr || rd_m !== rd || pc_plus4_m !== pc ||
                       result_src_m !== rs) begin miscompares++;
          $display("FAIL rnd%0d_pass got alu=%h rd=%0d pc=%h src=%0d want %h %0d %h %0d",
                   n, alu_result_m, rd_m, pc_plus4_m, result_src_m, addr, rd, pc, rs); end
        @(posedge clk); #1;
      end else begin
        // replayed memory op: drain it with an immediate ack
        dmem_ack = 1'b1;
        @(negedge clk);
        vectors++; if (stall_m !== 1'b0 || rd_m !== rd || pc_plus4_m !== pc) begin
          miscompares++;
          $display("FAIL rnd%0d_replay got stall=%0b rd=%0d pc=%h want 0 %0d %h",
                   n, stall_m, rd_m, pc_plus4_m, rd, pc); end
        @(posedge clk); #1; dmem_ack = 1'b0;
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    dmem_ack = 1'b0;
    dmem_rdata = 32'h0;
    test_reset();
    test_alu();
    test_lb_wait();
    test_sh();
    test_misaligned();
    test_back_to_back();
    test_reset_busy();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout got no completion want finish before 400000");
    $fatal(1, "timeout");
  end

endmodule
